// File: rtl/imm_encoder_loader_pkg.sv
// rtl/imm_encoder_loader_pkg.sv - shared immediate-source codes, error codes and range limits
package imm_encoder_loader_pkg;

  // ImmSrc coding shared with the immediate extender
  typedef enum logic [1:0] {
    IMM_I   = 2'b00,
    IMM_S   = 2'b01,
    IMM_B   = 2'b10,
    IMM_RSV = 2'b11
  } immSrcT;

  // Reasons a request is rejected
  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_BODD  = 2'b10,
    ERR_SRC   = 2'b11
  } errCodeT;

  // Immediate ranges the extender can reproduce exactly
  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational RV32I I/S/B field packer with immediate range checking
module imm_pack
  import imm_encoder_loader_pkg::*;
(
  input  logic [1:0]  immSrc,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad,
  output logic [1:0]  code
);

  logic signed [31:0] immS;
  assign immS = $signed(imm);

  // Pack fields into the instruction word and flag immediates the extender cannot round-trip
  always_comb begin
    word = '0;
    bad  = 1'b0;
    code = ERR_NONE;
    case (immSrc)
      IMM_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      IMM_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: word = '0;
    endcase
    if (immSrc == IMM_RSV) begin
      bad  = 1'b1;
      code = ERR_SRC;
    end else if (immSrc == IMM_B && imm[0]) begin
      bad  = 1'b1;
      code = ERR_BODD;
    end else if (immSrc == IMM_B && (immS < IMM_B_MIN || immS > IMM_B_MAX)) begin
      bad  = 1'b1;
      code = ERR_RANGE;
    end else if (immSrc != IMM_B && (immS < IMM_IS_MIN || immS > IMM_IS_MAX)) begin
      bad  = 1'b1;
      code = ERR_RANGE;
    end
  end

endmodule

// File: rtl/imm_encoder_loader.sv
// rtl/imm_encoder_loader.sv - encodes instruction requests and streams them into instruction memory
module imm_encoder_loader
  import imm_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_immsrc,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              addr_wrap
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [31:0] packWord;
  logic        packBad;
  logic [1:0]  packCode;

  imm_pack uPack (
    .immSrc (in_immsrc),
    .opcode (in_opcode),
    .rd     (in_rd),
    .funct3 (in_funct3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (packWord),
    .bad    (packBad),
    .code   (packCode)
  );

  logic [31:0]       fifoMem [2];
  logic              rdPtr;
  logic              wrPtr;
  logic [1:0]        fifoCount;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] addrQ;

  // in_ready depends only on registered occupancy, never on wr_ready
  assign in_ready = (fifoCount != 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = accept && !packBad;
  assign wr_en    = (fifoCount != 2'd0);
  assign pop      = wr_en && wr_ready;
  assign wr_data  = fifoMem[rdPtr];
  assign wr_addr  = addrQ;

  // Two-entry word FIFO; head stays put until the memory takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      rdPtr      <= 1'b0;
      wrPtr      <= 1'b0;
      fifoCount  <= 2'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= packWord;
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 2'd1;
        2'b01:   fifoCount <= fifoCount - 2'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // One-cycle error pulse for rejected requests; code holds until the next rejection
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err_valid <= accept && packBad;
      if (accept && packBad) err_code <= packCode;
    end
  end

  // Write address and completed-write count; restart wins over the increment
  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ      <= BASE;
      word_count <= '0;
      addr_wrap  <= 1'b0;
    end else if (restart) begin
      addrQ      <= BASE;
      word_count <= '0;
    end else if (pop) begin
      addrQ <= addrQ + 1'b1;
      if (addrQ == {ADDR_W{1'b1}}) addr_wrap <= 1'b1;
      if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// tb/tb_imm_encoder_loader.sv - directed self-checking bench for imm_encoder_loader
module tb_imm_encoder_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_immsrc;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;
  logic              addr_wrap;

  int testsRun = 0;
  int testsFailed = 0;

  imm_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_immsrc  (in_immsrc),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .word_count (word_count),
    .addr_wrap  (addr_wrap)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference immediate extender, input is instr[31:7]
  function automatic logic [31:0] extendImm(input logic [24:0] ins, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{ins[24]}}, ins[24:13]};
      2'b01:   return {{20{ins[24]}}, ins[24:18], ins[4:0]};
      2'b10:   return {{20{ins[24]}}, ins[0], ins[23:18], ins[4:1], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic setReq(input logic [1:0] src, input logic [6:0] opc, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    in_immsrc = src; in_opcode = opc; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Present a request and hold it until the accepting edge; returns 1 after that edge
  task automatic send(input logic [1:0] src, input logic [6:0] opc, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    setReq(src, opc, rd, f3, rs1, rs2, imm);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkEq("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [1:0]  errSrc  [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
  logic [31:0] errImm  [6] = '{32'd2048, 32'd3, 32'd0, -32'd2049, 32'd4096, -32'd2049};
  logic [1:0]  errExp  [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    setReq(2'b00, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkEq("rst_in_ready", 32'(in_ready), 32'd1);
    checkEq("rst_wr_en", 32'(wr_en), 32'd0);
    checkEq("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkEq("rst_word_count", 32'(word_count), 32'd0);
    checkEq("rst_addr_wrap", 32'(addr_wrap), 32'd0);
    checkEq("rst_err_valid", 32'(err_valid), 32'd0);

    // I-type
    send(2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, -32'd1);
    checkEq("i_wr_en", 32'(wr_en), 32'd1);
    checkEq("i_wr_addr", 32'(wr_addr), 32'd0);
    checkEq("i_wr_data", wr_data, 32'hFFF00093);
    checkEq("i_roundtrip", extendImm(wr_data[31:7], 2'b00), 32'hFFFFFFFF);
    @(posedge clk); #1;
    checkEq("i_word_count", 32'(word_count), 32'd1);
    checkEq("i_idle", 32'(wr_en), 32'd0);

    // S-type
    send(2'b01, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 32'd8);
    checkEq("s_wr_addr", 32'(wr_addr), 32'd1);
    checkEq("s_wr_data", wr_data, 32'h00512423);
    checkEq("s_roundtrip", extendImm(wr_data[31:7], 2'b01), 32'd8);
    @(posedge clk); #1;

    // B-type
    send(2'b10, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, -32'd4);
    checkEq("b_wr_addr", 32'(wr_addr), 32'd2);
    checkEq("b_wr_data", wr_data, 32'hFE000EE3);
    checkEq("b_roundtrip", extendImm(wr_data[31:7], 2'b10), 32'hFFFFFFFC);
    @(posedge clk); #1;
    checkEq("b_word_count", 32'(word_count), 32'd3);

    // Rejected requests
    for (int i = 0; i < 6; i++) begin
      send(errSrc[i], 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, errImm[i]);
      checkEq($sformatf("err%0d_valid", i), 32'(err_valid), 32'd1);
      checkEq($sformatf("err%0d_code", i), 32'(err_code), 32'(errExp[i]));
      checkEq($sformatf("err%0d_no_wr", i), 32'(wr_en), 32'd0);
      checkEq($sformatf("err%0d_addr", i), 32'(wr_addr), 32'd3);
      @(posedge clk); #1;
      checkEq($sformatf("err%0d_pulse", i), 32'(err_valid), 32'd0);
    end

    // Boundary immediates and address wrap
    send(2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2047);
    checkEq("imax_wr_data", wr_data, 32'h7FF00093);
    checkEq("imax_wr_addr", 32'(wr_addr), 32'd3);
    @(posedge clk); #1;
    checkEq("wrap_addr", 32'(wr_addr), 32'd0);
    checkEq("wrap_flag", 32'(addr_wrap), 32'd1);
    checkEq("wrap_count", 32'(word_count), 32'd4);
    send(2'b10, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'd4094);
    checkEq("bmax_wr_data", wr_data, 32'h7E000FE3);
    checkEq("bmax_roundtrip", extendImm(wr_data[31:7], 2'b10), 32'd4094);
    checkEq("bmax_wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #1;
    checkEq("sat_count", 32'(word_count), 32'd4);
    checkEq("sat_addr", 32'(wr_addr), 32'd1);

    // Idle restart
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checkEq("restart_addr", 32'(wr_addr), 32'd0);
    checkEq("restart_count", 32'(word_count), 32'd0);
    checkEq("restart_wrap_sticky", 32'(addr_wrap), 32'd1);

    // Backpressure with three back-to-back requests
    wr_ready = 1'b0;
    setReq(2'b00, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    setReq(2'b00, 7'h13, 5'd3, 3'd0, 5'd1, 5'd0, 32'd6);
    @(posedge clk); #1;
    setReq(2'b00, 7'h13, 5'd4, 3'd0, 5'd1, 5'd0, 32'd7);
    checkEq("bp_full", 32'(in_ready), 32'd0);
    checkEq("bp_wr_en", 32'(wr_en), 32'd1);
    checkEq("bp_head", wr_data, 32'h00508113);
    @(posedge clk); #1;
    checkEq("bp_stable", wr_data, 32'h00508113);
    checkEq("bp_still_full", 32'(in_ready), 32'd0);
    checkEq("bp_addr0", 32'(wr_addr), 32'd0);
    wr_ready = 1'b1;
    @(posedge clk); #1;
    checkEq("bp_second", wr_data, 32'h00608193);
    checkEq("bp_addr1", 32'(wr_addr), 32'd1);
    checkEq("bp_ready_again", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkEq("bp_third", wr_data, 32'h00708213);
    checkEq("bp_addr2", 32'(wr_addr), 32'd2);
    checkEq("bp_count", 32'(word_count), 32'd2);

    // Restart coinciding with a completed write
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checkEq("rs_wr_addr", 32'(wr_addr), 32'd0);
    checkEq("rs_count", 32'(word_count), 32'd0);
    checkEq("rs_empty", 32'(wr_en), 32'd0);
    send(2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd1);
    checkEq("rs_next_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #1;

    // Reset with a full FIFO
    wr_ready = 1'b0;
    send(2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd9);
    send(2'b00, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 32'd10);
    checkEq("rf_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkEq("rf_wr_en", 32'(wr_en), 32'd0);
    checkEq("rf_in_ready", 32'(in_ready), 32'd1);
    checkEq("rf_wrap", 32'(addr_wrap), 32'd0);
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkEq("rf_no_write", 32'(wr_en), 32'd0);
    checkEq("rf_count", 32'(word_count), 32'd0);
    checkEq("rf_addr", 32'(wr_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/imm_encoder_loader.md
Name: imm_encoder_loader

Overview:
- Inverse of the immediate extender: packs opcode, register and immediate fields into 32-bit RV32I I/S/B instruction words.
- Writes the words sequentially into instruction memory through a ready/valid write port.
- Used by the bench/boot path to build programs. Range-checks each immediate and rejects words the extender could not decode back to the same value.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address after reset or restart.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; one clock
- restart  input  1  reload write address to BASE_ADDR and clear word_count
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_immsrc  input  2  00 I, 01 S, 10 B, 11 reserved (same coding as extender ImmSrc)
- in_opcode  input  7  instr[6:0]
- in_rd  input  5  instr[11:7], I only
- in_funct3  input  3  instr[14:12]
- in_rs1  input  5  instr[19:15]
- in_rs2  input  5  instr[24:20], S/B only
- in_imm  input  32  signed immediate (B: byte offset)
- wr_en  output  1  write valid
- wr_ready  input  1  memory accepts; a write completes on wr_en && wr_ready
- wr_addr  output  ADDR_W  word address
- wr_data  output  32  encoded instruction
- err_valid  output  1  one-cycle pulse, request rejected
- err_code  output  2  01 range, 10 B odd, 11 reserved immsrc; valid with err_valid
- word_count  output  ADDR_W+1  completed writes since reset/restart, saturating
- addr_wrap  output  1  sticky; set when the address wraps

Behaviour:
- Reset: all outputs 0, except in_ready = 1 and wr_addr = BASE_ADDR. Buffer empty; addr_wrap cleared.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Checks, in priority order:
  - immsrc 11 gives code 11.
  - B with imm[0] = 1 gives code 10.
  - I/S imm outside -2048..2047 gives code 01.
  - B imm outside -4096..4094 gives code 01.
- Rejected requests still handshake. They are not enqueued. err_valid pulses the cycle after acceptance.
- Buffering: 2-entry FIFO of encoded words.
  - in_ready = !full. Not combinationally dependent on wr_ready.
  - Accepted word is visible on wr_en the next cycle.
  - Sustained throughput is 1 word/cycle while wr_ready = 1.
  - Simultaneous push and pop on a full FIFO is not allowed, since in_ready = 0.
  - Push and pop in the same cycle when 1 entry: occupancy stays 1.
- wr_en = FIFO non-empty. wr_data = head entry and is held stable while wr_en && !wr_ready.
- wr_addr is the address counter. It is assigned at write time, not at enqueue.
- Each completed write increments the address, modulo 2^ADDR_W. Wrapping from all-ones to 0 sets addr_wrap.
- word_count increments per completed write and saturates at 2^ADDR_W.
- restart in the same cycle as a completed write: the write uses the current address; next address = BASE_ADDR; word_count = 0. restart does not flush the FIFO.
- reset mid-operation: FIFO flushed, pending error pulse dropped, all counters cleared next edge.
- Round-trip invariant: extender(wr_data[31:7], immsrc) == in_imm for every accepted valid request.

Decomposition:
- Shared package:
  - ImmSrc codes IMM_I/IMM_S/IMM_B/IMM_RSV (shared with the extender)
  - error codes ERR_RANGE/ERR_BODD/ERR_SRC
  - range-limit constants
- One natural sub-module: imm_pack, a combinational encoder plus range checker.
- FIFO, counters and error register stay in the top block.

Test Plan:
- I, opcode 0x13, rd 1, rs1 0, f3 0, imm -1, wr_ready = 1 -> next cycle wr_en = 1, wr_addr 0, wr_data 0xFFF00093; word_count 1.
- S, opcode 0x23, f3 2, rs1 2, rs2 5, imm 8 -> wr_data 0x00512423 at addr 1.
- B, opcode 0x63, f3 0, rs1 0, rs2 0, imm -4 -> wr_data 0xFE000EE3. Extender round-trip returns 0xFFFFFFFC.
- Errors: I imm 2048 gives code 01; B imm 3 gives code 10; immsrc 11 gives code 01-priority-free 11. For each, err_valid pulses once, no wr_en, address unchanged.
- Backpressure: wr_ready = 0 with 3 back-to-back requests -> 2 accepted, in_ready = 0; wr_data stable. Release -> addr 0 and 1 written in order, third accepted.
- ADDR_W = 2: 5 writes -> addresses 0,1,2,3,0; addr_wrap = 1; word_count saturates at 4. restart mid-stream -> next write at BASE_ADDR. reset with full FIFO -> no further wr_en.
